ascon_job_scheduler: RTL and testbench

Sequences one Ascon fault-countermeasure core through complete encrypt-then-verify jobs. Each job runs encrypt, then decrypt of the resulting ciphertext, then an authentication check.
- Upstream: requesters hand over jobs on a valid/ready request channel; the block latches the operands and drives the core start strobes.
- Core side: the block watches the core ready levels, retries on authentication failure, and aborts on a watchdog timeout.
- Downstream: results return on a valid/ready response channel.

---
 rtl/ascon_sched_pkg.sv | 36 +++
 rtl/ascon_phase_watchdog.sv | 47 ++++
 rtl/ascon_job_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_ascon_job_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_sched_pkg
// Description : Shared encodings for the Ascon job scheduler and related
//               sequencers: FSM state codes, response status codes, widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_sched_pkg;

  localparam int STATE_W   = 3;
  localparam int STATUS_W  = 2;
  localparam int ATTEMPT_W = 3;
  localparam int NONCE_W   = 128;
  localparam int TAG_W     = 128;

  // Scheduler state encoding
  localparam logic [STATE_W-1:0] IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ENC_GO   = 3'd1;
  localparam logic [STATE_W-1:0] ENC_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] DEC_GO   = 3'd3;
  localparam logic [STATE_W-1:0] DEC_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] CHECK    = 3'd5;
  localparam logic [STATE_W-1:0] RESP     = 3'd6;

  // Response status codes
  localparam logic [STATUS_W-1:0] ST_OK        = 2'b00;
  localparam logic [STATUS_W-1:0] ST_AUTH_FAIL = 2'b01;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT   = 2'b10;

  // True in the states where the core is running and the watchdog counts
  function automatic logic is_wait_state(input logic [STATE_W-1:0] s);
    return (s == ENC_WAIT) || (s == DEC_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_phase_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : ascon_phase_watchdog
// Description : Per-phase cycle watchdog. Cleared at the start of a core
//               phase, counts while enabled, flags expiry on the cycle the
//               count reaches TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_phase_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = en && (cnt_q == CNT_LAST);

  // Next count: clear wins, then count up while enabled, saturating at expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ascon_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ascon_job_scheduler
// Description : Runs encrypt -> decrypt -> authentication check jobs on one
//               Ascon core, retrying on authentication failure and aborting
//               a phase that exceeds the watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_job_scheduler
  import ascon_sched_pkg::*;
#(
  parameter int K         = 128,
  parameter int L         = 40,
  parameter int Y         = 40,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // request channel
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [K-1:0]         req_key,
  input  logic [NONCE_W-1:0]   req_nonce,
  input  logic [L-1:0]         req_ad,
  input  logic [Y-1:0]         req_pt,
  // core side
  output logic [K-1:0]         core_key,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic [L-1:0]         core_ad,
  output logic [Y-1:0]         core_pt,
  output logic                 core_enc_start,
  output logic                 core_dec_start,
  input  logic [Y-1:0]         core_ct,
  input  logic [TAG_W-1:0]     core_tag,
  input  logic                 core_enc_ready,
  input  logic                 core_dec_ready,
  input  logic                 core_auth,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [Y-1:0]         rsp_ct,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [STATUS_W-1:0]  rsp_status,
  output logic [ATTEMPT_W-1:0] rsp_attempts,
  output logic                 busy
);

  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_d;

  logic [K-1:0]         key_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [L-1:0]         ad_q;
  logic [Y-1:0]         pt_q;
  logic [Y-1:0]         ct_q;
  logic [TAG_W-1:0]     tag_q;
  logic [STATUS_W-1:0]  status_q;
  logic [ATTEMPT_W-1:0] attempt_q;
  logic                 req_ready_q;
  logic                 enc_prev_q;
  logic                 dec_prev_q;

  logic w_accept;
  logic w_enc_edge;
  logic w_dec_edge;
  logic w_can_retry;
  logic w_expire;
  logic w_wd_clr;
  logic w_wd_en;

  // Only edges count as completion, so a level left high by a previous job
  // (or by a core still running across a reset) cannot end a phase early.
  assign w_enc_edge  = core_enc_ready && !enc_prev_q;
  assign w_dec_edge  = core_dec_ready && !dec_prev_q;
  assign w_accept    = req_valid && req_ready_q;
  assign w_can_retry = ({1'b0, attempt_q} <= 4'(MAX_RETRY));

  assign req_ready    = req_ready_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_ad      = ad_q;
  assign core_pt      = pt_q;
  assign rsp_ct       = ct_q;
  assign rsp_tag      = tag_q;
  assign rsp_status   = status_q;
  assign rsp_attempts = attempt_q;

  ascon_phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (w_wd_clr),
    .en     (w_wd_en),
    .expire (w_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready edge coinciding with expiry is a completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (w_accept) state_d = ENC_GO;
      ENC_GO:   state_d = ENC_WAIT;
      ENC_WAIT: begin
        if (w_enc_edge) begin
          state_d = DEC_GO;
        end else if (w_expire) begin
          state_d = RESP;
        end
      end
      DEC_GO:   state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (w_dec_edge) begin
          state_d = CHECK;
        end else if (w_expire) begin
          state_d = RESP;
        end
      end
      CHECK: begin
        if (!core_auth && w_can_retry) begin
          state_d = ENC_GO;
        end else begin
          state_d = RESP;
        end
      end
      RESP:     if (rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State-decoded outputs: strobes, response valid, busy, watchdog control
  always_comb begin
    core_enc_start = 1'b0;
    core_dec_start = 1'b0;
    rsp_valid      = 1'b0;
    w_wd_clr       = 1'b0;
    busy           = (state_q != IDLE);
    w_wd_en        = is_wait_state(state_q);
    case (state_q)
      ENC_GO: begin
        core_enc_start = 1'b1;
        w_wd_clr       = 1'b1;
      end
      DEC_GO: begin
        core_dec_start = 1'b1;
        w_wd_clr       = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request acceptance flag and ready-level history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_q <= 1'b0;
      enc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
    end else begin
      req_ready_q <= (state_d == IDLE);
      enc_prev_q  <= core_enc_ready;
      dec_prev_q  <= core_dec_ready;
    end
  end

  // Operand latch; held until the next accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
    end else if (w_accept) begin
      key_q   <= req_key;
      nonce_q <= req_nonce;
      ad_q    <= req_ad;
      pt_q    <= req_pt;
    end
  end

  // Result capture, attempt counting and final status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_q      <= '0;
      tag_q     <= '0;
      status_q  <= ST_OK;
      attempt_q <= '0;
    end else begin
      if (w_accept) begin
        attempt_q <= ATTEMPT_W'(1);
      end
      if ((state_q == ENC_WAIT) && w_enc_edge) begin
        ct_q  <= core_ct;
        tag_q <= core_tag;
      end
      if ((state_q == ENC_WAIT && !w_enc_edge && w_expire) ||
          (state_q == DEC_WAIT && !w_dec_edge && w_expire)) begin
        status_q <= ST_TIMEOUT;
      end
      if (state_q == CHECK) begin
        if (core_auth) begin
          status_q <= ST_OK;
        end else if (w_can_retry) begin
          attempt_q <= attempt_q + ATTEMPT_W'(1);
        end else begin
          status_q <= ST_AUTH_FAIL;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_job_scheduler
// Description : Directed bench for ascon_job_scheduler with a behavioural
//               core model (fixed latencies, scripted authentication).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_job_scheduler;

  localparam int TO   = 40;
  localparam int MR   = 2;
  localparam int ELAT = 30;
  localparam int DLAT = 30;

  localparam logic [127:0] KA  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NA  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [39:0]  ADA = 40'h4142434445;
  localparam logic [39:0]  PTA = 40'h5051525354;
  localparam logic [39:0]  CTA = 40'h5B5D5F5D5B;
  localparam logic [127:0] TGA = {16{8'h10}};

  localparam logic [127:0] KB  = {16{8'h5A}};
  localparam logic [127:0] NB  = {16{8'h33}};
  localparam logic [39:0]  ADB = 40'h1122334455;
  localparam logic [39:0]  PTB = 40'hCAFEBABE01;
  localparam logic [39:0]  CTB = 40'h90A4E0E45B;
  localparam logic [127:0] TGB = {16{8'h69}};

  localparam logic [127:0] KC  = {16{8'hC3}};
  localparam logic [127:0] NC  = {16{8'hF0}};
  localparam logic [39:0]  ADC = 40'h99AABBCCDD;
  localparam logic [39:0]  PTC = 40'h0123456789;
  localparam logic [39:0]  CTC = 40'hC2E086A44A;
  localparam logic [127:0] TGC = {16{8'h33}};

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         req_valid = 1'b0;
  logic         rsp_ready = 1'b0;
  logic [127:0] req_key   = '0;
  logic [127:0] req_nonce = '0;
  logic [39:0]  req_ad    = '0;
  logic [39:0]  req_pt    = '0;

  logic         req_ready;
  logic [127:0] core_key;
  logic [127:0] core_nonce;
  logic [39:0]  core_ad;
  logic [39:0]  core_pt;
  logic         core_enc_start;
  logic         core_dec_start;
  logic         rsp_valid;
  logic [39:0]  rsp_ct;
  logic [127:0] rsp_tag;
  logic [1:0]   rsp_status;
  logic [2:0]   rsp_attempts;
  logic         busy;

  logic [39:0]  core_ct        = '0;
  logic [127:0] core_tag       = '0;
  logic         core_enc_ready = 1'b0;
  logic         core_dec_ready = 1'b0;
  logic         core_auth;

  ascon_job_scheduler #(
    .K (128), .L (40), .Y (40), .TIMEOUT (TO), .MAX_RETRY (MR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_key        (req_key),
    .req_nonce      (req_nonce),
    .req_ad         (req_ad),
    .req_pt         (req_pt),
    .core_key       (core_key),
    .core_nonce     (core_nonce),
    .core_ad        (core_ad),
    .core_pt        (core_pt),
    .core_enc_start (core_enc_start),
    .core_dec_start (core_dec_start),
    .core_ct        (core_ct),
    .core_tag       (core_tag),
    .core_enc_ready (core_enc_ready),
    .core_dec_ready (core_dec_ready),
    .core_auth      (core_auth),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_ct         (rsp_ct),
    .rsp_tag        (rsp_tag),
    .rsp_status     (rsp_status),
    .rsp_attempts   (rsp_attempts),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter and strobe monitor
  int cyc          = 0;
  int enc_n        = 0;
  int dec_n        = 0;
  int overlap_n    = 0;
  int last_enc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_enc_start) begin
      enc_n        <= enc_n + 1;
      last_enc_cyc <= cyc;
    end
    if (core_dec_start) dec_n <= dec_n + 1;
    if (core_enc_start && core_dec_start) overlap_n <= overlap_n + 1;
  end

  // Core model: ready rises a fixed number of cycles after each start.
  // stale_mode keeps enc_ready high past the start, drops it, then raises it.
  logic stale_mode = 1'b0;
  logic enc_stuck  = 1'b0;
  int   enc_cnt    = 0;
  int   dec_cnt    = 0;
  always @(posedge clk) begin
    if (core_enc_start) begin
      enc_cnt <= stale_mode ? 10 : ELAT;
      if (!stale_mode) core_enc_ready <= 1'b0;
    end else if (enc_cnt > 0) begin
      enc_cnt <= enc_cnt - 1;
      if (stale_mode && enc_cnt == 6) core_enc_ready <= 1'b0;
      if (enc_cnt == 1 && !enc_stuck) begin
        core_enc_ready <= 1'b1;
        core_ct        <= core_pt ^ core_key[39:0];
        core_tag       <= core_nonce ^ core_key;
      end
    end
    if (core_dec_start) begin
      dec_cnt        <= DLAT;
      core_dec_ready <= 1'b0;
    end else if (dec_cnt > 0) begin
      dec_cnt <= dec_cnt - 1;
      if (dec_cnt == 1) core_dec_ready <= 1'b1;
    end
  end

  // Authentication result per decrypt attempt within the current job
  logic [7:0] auth_seq = 8'hFF;
  int enc_base = 0;
  int dec_base = 0;
  assign core_auth = (dec_n > dec_base) ? auth_seq[dec_n - dec_base - 1] : 1'b0;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] n,
                      input logic [39:0] a, input logic [39:0] p);
    int g;
    g = 0;
    enc_base  = enc_n;
    dec_base  = dec_n;
    req_key   = k;
    req_nonce = n;
    req_ad    = a;
    req_pt    = p;
    req_valid = 1'b1;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_accept_bound", 128'(g < 100), 128'(1));
  endtask

  task automatic wait_rsp(input int max_cyc, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < max_cyc && at < 0) begin
      if (rsp_valid) at = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("rsp_wait_bound", 128'(at >= 0), 128'(1));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 128'(rsp_valid), 128'(0));
    chk("idle_after_rsp", 128'(busy), 128'(0));
  endtask

  initial begin
    int at;
    int g;
    int e0;
    int d0;
    logic ok;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_core_key",  core_key,        128'(0));
    chk("rst_strobes",   128'({core_enc_start, core_dec_start}), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));
    chk("post_rst_busy",      128'(busy),      128'(0));

    // ---------------- single job OK ----------------
    auth_seq = 8'hFF;
    send(KA, NA, ADA, PTA);
    chk("ok_core_ad", 128'(core_ad), 128'(ADA));
    chk("ok_core_pt", 128'(core_pt), 128'(PTA));
    wait_rsp(200, at);
    chk("ok_latency",  128'(at - last_enc_cyc), 128'(ELAT + DLAT + 5));
    chk("ok_status",   128'(rsp_status),   128'(2'b00));
    chk("ok_attempts", 128'(rsp_attempts), 128'(1));
    chk("ok_ct",       128'(rsp_ct),       128'(CTA));
    chk("ok_tag",      rsp_tag,            TGA);
    chk("ok_enc_n",    128'(enc_n - enc_base), 128'(1));
    chk("ok_dec_n",    128'(dec_n - dec_base), 128'(1));
    handshake();

    // ---------------- auth retry ----------------
    auth_seq = 8'b0000_0010;
    send(KA, NA, ADA, PTA);
    wait_rsp(400, at);
    chk("retry_status",   128'(rsp_status),   128'(2'b00));
    chk("retry_attempts", 128'(rsp_attempts), 128'(2));
    chk("retry_enc_n",    128'(enc_n - enc_base), 128'(2));
    handshake();

    // ---------------- auth exhausted ----------------
    auth_seq = 8'h00;
    send(KA, NA, ADA, PTA);
    wait_rsp(600, at);
    chk("exh_status",   128'(rsp_status),   128'(2'b01));
    chk("exh_attempts", 128'(rsp_attempts), 128'(3));
    chk("exh_enc_n",    128'(enc_n - enc_base), 128'(3));
    chk("exh_dec_n",    128'(dec_n - dec_base), 128'(3));
    handshake();

    // ---------------- stale ready + backpressure ----------------
    stale_mode = 1'b1;
    auth_seq   = 8'hFF;
    send(KB, NB, ADB, PTB);
    wait_rsp(200, at);
    chk("stale_latency", 128'(at - last_enc_cyc), 128'(10 + DLAT + 5));
    chk("stale_ct",      128'(rsp_ct), 128'(CTB));
    chk("stale_tag",     rsp_tag,      TGB);
    req_key   = KC;
    req_nonce = NC;
    req_ad    = ADC;
    req_pt    = PTC;
    req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_ct == CTB && rsp_tag == TGB && rsp_status == 2'b00 &&
            rsp_attempts == 3'd1 && !req_ready && core_key == KB))
        ok = 1'b0;
    end
    chk("bp_hold_stable", 128'(ok), 128'(1));
    stale_mode = 1'b0;
    enc_base   = enc_n;
    dec_base   = dec_n;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rsp_drop",  128'(rsp_valid), 128'(0));
    chk("bp_req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_accept", 128'(core_enc_start), 128'(1));
    chk("bp_second_key",    core_key,             KC);
    chk("bp_busy_ready",    128'({busy, req_ready}), 128'(2'b10));
    wait_rsp(200, at);
    chk("second_ct", 128'(rsp_ct), 128'(CTC));
    handshake();

    // ---------------- timeout ----------------
    enc_stuck = 1'b1;
    send(KA, NA, ADA, PTA);
    wait_rsp(200, at);
    chk("to_latency",  128'(at - last_enc_cyc), 128'(TO + 1));
    chk("to_status",   128'(rsp_status),   128'(2'b10));
    chk("to_attempts", 128'(rsp_attempts), 128'(1));
    chk("to_dec_n",    128'(dec_n - dec_base), 128'(0));
    chk("to_ct_held",  128'(rsp_ct), 128'(CTC));
    chk("to_tag_held", rsp_tag,      TGC);
    handshake();
    enc_stuck = 1'b0;

    // ---------------- async reset mid DEC_WAIT ----------------
    send(KA, NA, ADA, PTA);
    g = 0;
    while (dec_n == dec_base && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("mid_reach_dec", 128'(g < 200), 128'(1));
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("mid_rst_busy",      128'(busy),      128'(0));
    chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
    chk("mid_rst_core_key",  core_key,        128'(0));
    chk("mid_rst_rsp_ct",    128'(rsp_ct),    128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_req_ready", 128'(req_ready), 128'(1));
    chk("mid_rel_busy",      128'(busy),      128'(0));
    e0 = enc_n;
    d0 = dec_n;
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) ok = 1'b0;
    end
    chk("mid_quiet",     128'(ok),         128'(1));
    chk("mid_no_enc",    128'(enc_n - e0), 128'(0));
    chk("mid_no_dec",    128'(dec_n - d0), 128'(0));
    chk("never_overlap", 128'(overlap_n),  128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
